// File: rtl/adc_sample_sequencer_if.sv
// adc_sample_sequencer_if: ADC conversion handshake bundle
// adc_req  request from sequencer, held until adc_rdy is seen high
// adc_rst  active-high ADC reset pulse from sequencer
// adc_rdy  4-phase acknowledge from ADC
// adc_dat  ADC sample, valid while adc_rdy is high
// master = sequencer side, slave = ADC side
interface adc_sample_sequencer_if;
  logic       adc_req;
  logic       adc_rst;
  logic       adc_rdy;
  logic [7:0] adc_dat;
  modport master (output adc_req, output adc_rst, input adc_rdy, input adc_dat);
  modport slave (input adc_req, input adc_rst, output adc_rdy, output adc_dat);
endinterface

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: periodic ADC sampler with 4-phase handshake and timestamps
// clk, reset   clock and asynchronous active-high reset
// i_start      one-cycle pulse that begins a capture run (ignored while busy)
// i_stop       one-cycle pulse that ends a capture run
// i_divisor    sample period in clk cycles, latched on accepted start (0 acts as 1)
// adc          handshake interface, master side
// o_smp_valid  one-cycle strobe for o_smp_data/o_smp_time
// o_smp_data   last captured sample
// o_smp_time   timestamp of last captured sample
// o_busy       high whenever not idle
// o_overrun    sticky: a sample tick arrived during a handshake and was dropped
// o_err        sticky: ADC handshake timeout
// Optional macro ADC_SAMPLE_SEQUENCER_TIMEOUT_EN adds the request watchdog;
// without it REQ waits forever and o_err is tied low.
module adc_sample_sequencer #(
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_start,
  input  logic                          i_stop,
  input  logic [15:0]                   i_divisor,
  adc_sample_sequencer_if.master        adc,
  output logic                          o_smp_valid,
  output logic [7:0]                    o_smp_data,
  output logic [31:0]                   o_smp_time,
  output logic                          o_busy,
  output logic                          o_overrun,
  output logic                          o_err
);
  if (RST_CYCLES < 1 || RST_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("adc_sample_sequencer: parameter out of range");
  end
  typedef enum logic [2:0] {IDLE, ADC_RST, WAIT_TICK, REQ, WAIT_LOW} state_t;
  state_t      r_state;
  logic [15:0] r_period;
  logic [15:0] r_tick_cnt;
  logic [7:0]  r_rst_cnt;
  logic [31:0] r_ts;
  logic [31:0] r_time;
  logic [7:0]  r_data;
  logic        r_req;
  logic        r_rst;
  logic        r_armed;
  logic        r_stop_pend;
  logic        r_valid;
  logic        r_overrun;
  logic        w_run;
  logic        w_tick;
  logic        w_ack;
  logic        w_timeout;
  logic        w_accept;
  assign w_run    = r_state inside {WAIT_TICK, REQ, WAIT_LOW};
  assign w_tick   = w_run && r_tick_cnt == 16'd1;
  // a capture needs adc_rdy to have been seen low since the request rose
  assign w_ack    = r_state == REQ && adc.adc_rdy && r_armed;
  assign w_accept = r_state == IDLE && i_start && !i_stop;
`ifdef ADC_SAMPLE_SEQUENCER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_err;
  assign w_timeout = r_state == REQ && !w_ack && r_to_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign o_err     = r_err;
  // REQ is always entered from WAIT_TICK, so the counter is back at 0 on entry
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= r_state == REQ ? r_to_cnt + 1'b1 : '0;
      r_err    <= w_accept ? 1'b0 : r_err | w_timeout;
    end
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state     <= IDLE;
      r_period    <= '0;
      r_tick_cnt  <= '0;
      r_rst_cnt   <= '0;
      r_ts        <= '0;
      r_time      <= '0;
      r_data      <= '0;
      r_req       <= 1'b0;
      r_rst       <= 1'b0;
      r_armed     <= 1'b0;
      r_stop_pend <= 1'b0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state != IDLE) r_ts <= r_ts + 32'd1;
      if (w_run) r_tick_cnt <= w_tick ? r_period : r_tick_cnt - 16'd1;
      if (w_tick && r_state != WAIT_TICK) r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (w_accept) begin
          r_state     <= ADC_RST;
          r_rst       <= 1'b1;
          r_rst_cnt   <= 8'(RST_CYCLES - 1);
          r_period    <= i_divisor == 16'd0 ? 16'd1 : i_divisor;
          r_ts        <= '0;
          r_overrun   <= 1'b0;
          r_stop_pend <= 1'b0;
        end
        ADC_RST: if (i_stop) begin
          r_state <= IDLE;
          r_rst   <= 1'b0;
        end else if (r_rst_cnt == 8'd0) begin
          r_state    <= WAIT_TICK;
          r_rst      <= 1'b0;
          r_tick_cnt <= r_period;
        end else r_rst_cnt <= r_rst_cnt - 8'd1;
        WAIT_TICK: if (i_stop) r_state <= IDLE;
        else if (w_tick) begin
          r_state <= REQ;
          r_req   <= 1'b1;
          r_armed <= !adc.adc_rdy;
        end
        REQ: begin
          if (i_stop) r_stop_pend <= 1'b1;
          if (!adc.adc_rdy) r_armed <= 1'b1;
          if (w_ack) begin
            r_state <= WAIT_LOW;
            r_req   <= 1'b0;
            r_data  <= adc.adc_dat;
            r_time  <= r_ts;
            r_valid <= 1'b1;
          end else if (w_timeout) begin
            r_req     <= 1'b0;
            r_state   <= r_stop_pend || i_stop ? IDLE : ADC_RST;
            r_rst     <= !(r_stop_pend || i_stop);
            r_rst_cnt <= 8'(RST_CYCLES - 1);
          end
        end
        WAIT_LOW: begin
          if (i_stop) r_stop_pend <= 1'b1;
          if (!adc.adc_rdy) r_state <= r_stop_pend || i_stop ? IDLE : WAIT_TICK;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign adc.adc_req = r_req;
  assign adc.adc_rst = r_rst;
  assign o_smp_valid = r_valid;
  assign o_smp_data  = r_data;
  assign o_smp_time  = r_time;
  assign o_busy      = r_state != IDLE;
  assign o_overrun   = r_overrun;
endmodule
